// File: rtl/mul_hilo_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer.
//   - operation encodings presented on iOp
//   - FSM state encodings (IDLE -> CALC -> FIX -> IDLE)
package mul_hilo_sequencer_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIX   = 2'd2;

endpackage

// File: rtl/mul_hilo_sequencer_pp_step.sv
// mul_pp_step: combinational partial-product step of the shift-add multiplier.
// Adds (mcand << k) into the running accumulator for every set multiplier bit k
// among the BPC bits retired this cycle. All arithmetic is modulo 2^64.
// Ports:
//   mcand       in  64   current (already pre-shifted) multiplicand
//   mplier_bits in  BPC  low multiplier bits consumed this cycle
//   acc         in  64   accumulator before this step
//   acc_next    out 64   accumulator after this step
module mul_pp_step #(
  parameter int BPC = 4
) (
  input  logic [63:0]    mcand,
  input  logic [BPC-1:0] mplier_bits,
  input  logic [63:0]    acc,
  output logic [63:0]    acc_next
);

  logic [63:0] sum_s;

  // Sum of the selected shifted multiplicands onto the accumulator.
  always_comb begin
    sum_s = acc;
    for (int k = 0; k < BPC; k++) begin
      if (mplier_bits[k]) begin
        sum_s = sum_s + (mcand << k);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  assign acc_next = sum_s;

endmodule

// File: rtl/mul_hilo_sequencer.sv
// mul_hilo_sequencer: multi-cycle multiplier owning the HI/LO registers for
// MULT/MULTU/MTHI/MTLO. Signed multiply is done on magnitudes, the sign is
// applied by a 64-bit negate in the FIX cycle so HI/LO are written atomically.
// Ports:
//   iClk     in  1   clock (rising edge)
//   iRst_n   in  1   asynchronous active-low reset
//   iStart   in  1   request, accepted when oReady=1
//   iOp      in  2   MULTU/MULT/MTHI/MTLO
//   iA, iB   in  32  operands, sampled on the accept edge only
//   iCancel  in  1   flush; aborts a multiply in progress, blocks accept
//   oReady   out 1   combinational: IDLE and no cancel
//   oBusy    out 1   registered: multiply in CALC or FIX
//   oDone    out 1   registered one-cycle pulse after HI/LO take a product
//   oHi/oLo  out 32  HI and LO registers
module mul_hilo_sequencer
  import mul_hilo_sequencer_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic [1:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iCancel,
  output logic        oReady,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oHi,
  output logic [31:0] oLo
);

  localparam logic [5:0] STEPS = 6'(32 / BPC);

  logic [1:0]  state_r;
  logic [5:0]  cnt_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic [63:0] acc_r;
  logic        neg_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  logic        accept_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        neg_s;
  logic [63:0] acc_next_s;
  logic [63:0] product_s;

  assign oReady   = (state_r == ST_IDLE) & ~iCancel;
  assign accept_s = iStart & oReady;

  // Operand magnitudes; 0x80000000 negates to itself, which read unsigned is correct.
  always_comb begin
    if (iOp == OP_MULT) begin
      a_mag_s = iA[31] ? (32'd0 - iA) : iA;
      b_mag_s = iB[31] ? (32'd0 - iB) : iB;
      neg_s   = iA[31] ^ iB[31];
    end else begin
      a_mag_s = iA;
      b_mag_s = iB;
      neg_s   = 1'b0;
    end
  end

  mul_pp_step #(.BPC(BPC)) u_pp_step (
    .mcand       (mcand_r),
    .mplier_bits (mplier_r[BPC-1:0]),
    .acc         (acc_r),
    .acc_next    (acc_next_s)
  );

  assign product_s = neg_r ? (64'd0 - acc_r) : acc_r;

  // FSM, operand/accumulator datapath and HI/LO ownership.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 6'd0;
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      acc_r    <= 64'd0;
      neg_r    <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (iOp)
              OP_MTHI: hi_r <= iA;
              OP_MTLO: lo_r <= iA;
              OP_MULT, OP_MULTU: begin
                mcand_r  <= {32'd0, a_mag_s};
                mplier_r <= b_mag_s;
                neg_r    <= neg_s;
                acc_r    <= 64'd0;
                cnt_r    <= STEPS;
                busy_r   <= 1'b1;
                state_r  <= ST_CALC;
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_CALC: begin
          if (iCancel) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << BPC;
            mplier_r <= mplier_r >> BPC;
            cnt_r    <= cnt_r - 6'd1;
            if (cnt_r == 6'd1) begin
              state_r <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
          if (!iCancel) begin
            hi_r   <= product_s[63:32];
            lo_r   <= product_s[31:0];
            done_r <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign oBusy = busy_r;
  assign oDone = done_r;
  assign oHi   = hi_r;
  assign oLo   = lo_r;

endmodule
